// File: rtl/tx_fifo_rd_drain.sv
// tx_fifo_rd_drain: read-side drain stage of the TX packet data FIFO.
// Pops words from FIFO storage (one cycle read latency) into a 2-entry skid
// buffer and presents them on a valid/ready stream to the MAC. A packet starts
// when a complete packet is committed or enough words are buffered. An
// inter-packet gap is forced after every EOP word.
module tx_fifo_rd_drain #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int START_THRESH = 8,
    parameter int IPG_CYCLES   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   i_wr_ptr,
    input  logic              i_pkt_commit,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W:0]   i_mem_rd_data,
    output logic [ADDR_W:0]   o_rd_ptr,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_underrun,
    output logic [15:0]       o_underrun_cnt
);

    localparam logic [ADDR_W:0] PTR_ZERO   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] THRESH     = (ADDR_W+1)'(START_THRESH);
    localparam logic [7:0]      IPG_LAST   = 8'(IPG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_IPG    = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [DATA_W:0]   r_skid [2];
    logic [1:0]        r_skid_cnt;
    logic              r_inflight;
    logic              r_eop_fetched;
    logic              r_sent;
    logic [ADDR_W:0]   r_pending;
    logic [7:0]        r_ipg_cnt;
    logic              r_underrun;
    logic [15:0]       r_underrun_cnt;

    logic [ADDR_W:0]   w_occ;
    logic              w_xfer;
    logic              w_xfer_last;
    logic              w_ret_eop;
    logic [2:0]        w_slots;
    logic              w_rd_en;
    logic              w_underrun;

    // Occupancy uses the wrap bit so that full and empty are distinguishable.
    assign w_occ       = i_wr_ptr - r_rd_ptr;
    assign w_xfer      = (r_skid_cnt != 2'd0) & i_out_ready;
    assign w_xfer_last = w_xfer & r_skid[0][DATA_W];
    // EOP arriving from storage stops prefetch in the very cycle it returns,
    // so nothing beyond the packet end is ever read.
    assign w_ret_eop   = r_inflight & i_mem_rd_data[DATA_W];
    // Words held or owed after this cycle's pop; a pop frees a slot for a
    // same-cycle issue, which is what sustains one word per cycle.
    assign w_slots     = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_rd_en     = ~rst & (r_state == ST_STREAM) & (w_occ != PTR_ZERO)
                         & ~r_eop_fetched & ~w_ret_eop & (w_slots < 3'd2);
    // Starvation only counts once a word of the packet has gone out; r_sent
    // is cleared on each event so one dry spell is reported once.
    assign w_underrun  = (r_state == ST_STREAM) & i_out_ready & (r_skid_cnt == 2'd0)
                         & ~r_inflight & (w_occ == PTR_ZERO) & r_sent;

    assign o_mem_rd_en    = w_rd_en;
    assign o_mem_rd_addr  = r_rd_ptr[ADDR_W-1:0];
    assign o_rd_ptr       = r_rd_ptr;
    assign o_out_valid    = (r_skid_cnt != 2'd0);
    assign o_out_data     = r_skid[0][DATA_W-1:0];
    assign o_out_last     = (r_skid_cnt != 2'd0) & r_skid[0][DATA_W];
    assign o_busy         = (r_state != ST_IDLE);
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;

    // Read pointer advance and one-deep in-flight tracking of storage reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= PTR_ZERO;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Two-entry skid buffer: returned words push in, stream transfers pop the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_cnt <= 2'd0;
            r_skid[0]  <= {(DATA_W+1){1'b0}};
            r_skid[1]  <= {(DATA_W+1){1'b0}};
        end else begin
            case ({r_inflight, w_xfer})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_skid[0] <= i_mem_rd_data;
                    end else begin
                        r_skid[1] <= i_mem_rd_data;
                    end
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_skid[0]  <= r_skid[1];
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd2) begin
                        r_skid[0] <= r_skid[1];
                        r_skid[1] <= i_mem_rd_data;
                    end else begin
                        r_skid[0] <= i_mem_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count of committed packets not yet fully sent; never drops below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= PTR_ZERO;
        end else begin
            case ({i_pkt_commit, w_xfer_last})
                2'b10: r_pending <= r_pending + PTR_ONE;
                2'b01: begin
                    if (r_pending != PTR_ZERO) begin
                        r_pending <= r_pending - PTR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Packet sequencing: wait for a start condition, stream to EOP, hold the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ipg_cnt     <= 8'd0;
            r_eop_fetched <= 1'b0;
            r_sent        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_eop_fetched <= 1'b0;
                    r_sent        <= 1'b0;
                    if ((r_pending != PTR_ZERO) || (w_occ >= THRESH)) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_ret_eop) begin
                        r_eop_fetched <= 1'b1;
                    end
                    if (w_xfer_last) begin
                        r_eop_fetched <= 1'b0;
                        r_sent        <= 1'b0;
                        r_ipg_cnt     <= 8'd0;
                        if (IPG_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_IPG;
                        end
                    end else if (w_underrun) begin
                        r_sent <= 1'b0;
                    end else if (w_xfer) begin
                        r_sent <= 1'b1;
                    end
                end
                ST_IPG: begin
                    if (r_ipg_cnt == IPG_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ipg_cnt <= r_ipg_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Underrun pulse and its saturating event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else begin
            r_underrun <= w_underrun;
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_fifo_rd_drain.sv
// Testbench for tx_fifo_rd_drain: models the write stage and FIFO storage,
// keeps an ordered scoreboard of written words and checks the stream side
// from an independent monitor process.
module tb_tx_fifo_rd_drain;

    localparam int IPG = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  wr_ptr;
    logic        pkt_commit;
    logic        mem_rd_en;
    logic [4:0]  mem_rd_addr;
    logic [64:0] mem_rd_data;
    logic [5:0]  rd_ptr;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_cnt;

    logic [64:0] mem [0:31];
    logic [64:0] exp_q [$];
    logic [4:0]  addr_q [$];
    int          xfer_cyc [$];
    int          checks = 0;
    int          errors = 0;
    int          xfer_n = 0;
    int          ur_pulses = 0;
    int          cyc = 0;
    logic        wr_done;

    tx_fifo_rd_drain #(
        .DATA_W(64), .ADDR_W(5), .START_THRESH(8), .IPG_CYCLES(IPG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_wr_ptr       (wr_ptr),
        .i_pkt_commit   (pkt_commit),
        .o_mem_rd_en    (mem_rd_en),
        .o_mem_rd_addr  (mem_rd_addr),
        .i_mem_rd_data  (mem_rd_data),
        .o_rd_ptr       (rd_ptr),
        .o_out_valid    (out_valid),
        .o_out_data     (out_data),
        .o_out_last     (out_last),
        .i_out_ready    (out_ready),
        .o_busy         (busy),
        .o_underrun     (underrun),
        .o_underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // FIFO storage with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=waiting expected=done", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-stage model: store word, advance pointer, pulse commit on EOP
    task automatic write_word(input logic [63:0] d, input logic eop, input logic commit);
        int t = 0;
        while (6'(wr_ptr - rd_ptr) == 6'd32 && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) timeout("wr_space");
        mem[wr_ptr[4:0]] = {eop, d};
        wr_ptr = wr_ptr + 6'd1;
        pkt_commit = commit;
        exp_q.push_back({eop, d});
        tick();
        pkt_commit = 1'b0;
    endtask

    task automatic write_pkt(input int len);
        for (int i = 0; i < len; i++)
            write_word({$urandom, $urandom}, (i == len - 1), (i == len - 1));
    endtask

    task automatic wait_xfers(input int n, input string name);
        int t = 0;
        while (xfer_n < n && t < 2000) begin
            tick();
            t++;
        end
        if (xfer_n < n) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            tick();
            t++;
        end
        if (t >= 5000) timeout(name);
        for (int i = 0; i < 8; i++) tick();
        check({name, "_idle"}, busy, 1'b0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard compare on every transfer, stall hold, gap length
    initial begin
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data = 64'd0;
        logic        gap_armed = 1'b0;
        int          gap_cnt = 0;
        logic [64:0] expw;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                gap_armed  = 1'b0;
            end else begin
                if (mem_rd_en) addr_q.push_back(mem_rd_addr);
                if (underrun) ur_pulses++;
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, prev_data);
                end
                if (gap_armed && out_valid) begin
                    check("ipg_gap_ge3", (gap_cnt >= IPG), 1'b1);
                    gap_armed = 1'b0;
                end else if (gap_armed) begin
                    gap_cnt++;
                end
                if (out_valid && out_ready) begin
                    xfer_n++;
                    xfer_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra actual=%0h expected=none", {out_last, out_data});
                    end else begin
                        expw = exp_q.pop_front();
                        check("sb_word", {out_last, out_data}, expw);
                    end
                    if (out_last) begin
                        gap_armed = 1'b1;
                        gap_cnt   = 0;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ur_base;
        logic [5:0] fill;
        logic [3:0] pat;

        for (int i = 0; i < 32; i++) mem[i] = 65'd0;
        rst = 1'b1; wr_ptr = 6'd0; pkt_commit = 1'b0; out_ready = 1'b0; wr_done = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_rd_ptr", rd_ptr, 6'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ur_cnt", underrun_cnt, 16'd0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // 1: 4-word packet, back-to-back, exact gap, pointer
        base = xfer_n;
        xfer_cyc.delete();
        write_pkt(4);
        wait_xfers(base + 4, "t1_xfers");
        for (int i = 0; i < IPG; i++) begin
            check("t1_gap_valid", out_valid, 1'b0);
            check("t1_gap_busy", busy, 1'b1);
            tick();
        end
        check("t1_busy_end", busy, 1'b0);
        check("t1_rd_ptr", rd_ptr, 6'd4);
        check("t1_xfer_n", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) check("t1_b2b", xfer_cyc[3] - xfer_cyc[0], 3);
        wait_drain("t1");

        // 2: threshold start without commit, then one underrun
        base = xfer_n;
        ur_base = ur_pulses;
        for (int i = 0; i < 10; i++) write_word({$urandom, $urandom}, 1'b0, 1'b0);
        wait_xfers(base + 10, "t2_xfers");
        repeat (20) tick();
        check("t2_ur_pulses", ur_pulses - ur_base, 1);
        check("t2_ur_cnt", underrun_cnt, 16'd1);
        check("t2_busy", busy, 1'b1);
        write_word({$urandom, $urandom}, 1'b1, 1'b1);
        wait_drain("t2");

        // 3: ready pattern 1,0,0,1 while streaming
        pat = 4'b1001;
        fork
            write_pkt(4);
            for (int k = 0; k < 48; k++) begin
                out_ready = pat[k % 4];
                tick();
            end
        join
        out_ready = 1'b1;
        wait_drain("t3");

        // 4: pointer wrap over a 3-word packet
        fill = 6'h1E - wr_ptr;
        if (fill != 6'd0) write_pkt(int'(fill));
        wait_drain("t4_fill");
        check("t4_rd_ptr_pre", rd_ptr, 6'h1E);
        addr_q.delete();
        write_pkt(3);
        wait_drain("t4");
        check("t4_addr_n", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("t4_addr0", addr_q[0], 5'd30);
            check("t4_addr1", addr_q[1], 5'd31);
            check("t4_addr2", addr_q[2], 5'd0);
        end
        check("t4_rd_ptr", rd_ptr, 6'h21);

        // 6: commit coincident with EOP transfer of the only pending packet
        out_ready = 1'b0;
        write_word({$urandom, $urandom}, 1'b1, 1'b1);
        write_word({$urandom, $urandom}, 1'b0, 1'b0);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin
                tick();
                t++;
            end
            if (!out_valid) timeout("t6_valid");
        end
        out_ready = 1'b1;
        write_word({$urandom, $urandom}, 1'b1, 1'b1);
        wait_drain("t6");

        // 5: reset after 2 of 5 words
        base = xfer_n;
        write_pkt(5);
        wait_xfers(base + 2, "t5_xfers");
        rst = 1'b1;
        wr_ptr = 6'd0;
        pkt_commit = 1'b0;
        tick();
        check("t5_valid", out_valid, 1'b0);
        check("t5_rd_ptr", rd_ptr, 6'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_ur_cnt", underrun_cnt, 16'd0);
        check("t5_xfers", xfer_n - base, 2);
        tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
        ur_base = ur_pulses;

        // Random packets with random backpressure
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    write_pkt($urandom_range(1, 12));
                    repeat ($urandom_range(0, 4)) tick();
                end
                wr_done = 1'b1;
            end
            begin
                int k = 0;
                while (!(wr_done && exp_q.size() == 0) && k < 20000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    k++;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand");
        check("rand_ur_pulses", ur_pulses - ur_base, 0);
        check("rand_ur_cnt", underrun_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
